// File: rtl/dstack_pkg.sv
// Shared definitions for the data-stack controller: op codes, FSM states and
// default stack geometry.
package dstack_pkg;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_PUSH  = 3'd1;
  localparam logic [2:0] OP_DROP  = 3'd2;
  localparam logic [2:0] OP_DUP   = 3'd3;
  localparam logic [2:0] OP_SWAP  = 3'd4;
  localparam logic [2:0] OP_OVER  = 3'd5;
  localparam logic [2:0] OP_BINOP = 3'd6;
  localparam logic [2:0] OP_CLEAR = 3'd7;

  typedef enum logic [1:0] {
    StIdle,
    StWrite2,
    StSettle
  } state_e;

  localparam logic [15:0] DefBaseAddr  = 16'd32;
  localparam int unsigned DefStackSize = 32;

  // Ops that add a cell and can therefore overflow.
  function automatic logic is_push_op(input logic [2:0] op);
    return (op == OP_PUSH) || (op == OP_DUP) || (op == OP_OVER);
  endfunction

endpackage

// File: rtl/dstack_ctrl.sv
// Data-stack controller: maps Forth stack ops onto stack-memory read/write
// addresses, write data and strobes, tracking SP, depth and sticky flags.
module dstack_ctrl
  import dstack_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR  = DefBaseAddr,
  parameter int unsigned STACK_SIZE = DefStackSize,
  parameter int unsigned DEPTH_W    = 6
) (
  input  logic               c_CLOCK,
  input  logic               f_RESETN,
  input  logic               i_VALID,
  output logic               o_READY,
  input  logic [2:0]         i_OP,
  input  logic [15:0]        i_DATA,
  input  logic [15:0]        i_OP1,
  input  logic [15:0]        i_OP2,
  output logic [15:0]        o_RADDR,
  output logic [15:0]        o_WADDR,
  output logic [15:0]        o_DATA,
  output logic               f_WRITE,
  output logic [DEPTH_W-1:0] o_DEPTH,
  output logic               f_OVF,
  output logic               f_UNF
);

  localparam logic [15:0]        SpEmpty   = BASE_ADDR - 16'd1;
  localparam logic [DEPTH_W-1:0] DepthZero = '0;
  localparam logic [DEPTH_W-1:0] DepthOne  = DEPTH_W'(1);
  localparam logic [DEPTH_W-1:0] DepthTwo  = DEPTH_W'(2);
  localparam logic [DEPTH_W-1:0] DepthFull = DEPTH_W'(STACK_SIZE);

  state_e             state_q, state_d;
  logic [15:0]        sp_q, sp_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               write_q, write_d;
  logic [15:0]        waddr_q, waddr_d;
  logic [15:0]        wdata_q, wdata_d;
  logic [15:0]        hold_q, hold_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;

  logic accept;
  logic has_room, has_one, has_two;
  logic op_legal;
  logic op_ovf, op_unf;
  logic op_go;

  assign accept   = i_VALID && (state_q == StIdle);
  assign has_room = depth_q < DepthFull;
  assign has_one  = depth_q >= DepthOne;
  assign has_two  = depth_q >= DepthTwo;

  // Depth legality of the presented op; underflow wins over overflow.
  always_comb begin
    op_unf = 1'b0;
    op_ovf = 1'b0;
    unique case (i_OP)
      OP_DROP:            op_unf = !has_one;
      OP_DUP:             op_unf = !has_one;
      OP_SWAP, OP_BINOP:  op_unf = !has_two;
      OP_OVER:            op_unf = !has_two;
      default:            op_unf = 1'b0;
    endcase
    if (!op_unf && is_push_op(i_OP)) begin
      op_ovf = !has_room;
    end
  end

  assign op_legal = !op_unf && !op_ovf;
  assign op_go    = accept && op_legal && (i_OP != OP_NOP);

  // FSM state register.
  always_ff @(posedge c_CLOCK) begin
    if (!f_RESETN) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (op_go) begin
          state_d = (i_OP == OP_SWAP) ? StWrite2 : StSettle;
        end
      end
      StWrite2: state_d = StSettle;
      StSettle: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    o_READY = (state_q == StIdle);
    o_RADDR = sp_q;
    o_WADDR = waddr_q;
    o_DATA  = wdata_q;
    f_WRITE = write_q;
    o_DEPTH = depth_q;
    f_OVF   = ovf_q;
    f_UNF   = unf_q;
  end

  // Datapath next state.
  always_comb begin
    sp_d    = sp_q;
    depth_d = depth_q;
    write_d = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    hold_d  = hold_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;

    if (state_q == StWrite2) begin
      write_d = 1'b1;
      waddr_d = sp_q;
      wdata_d = hold_q;
    end else if (accept) begin
      if (op_ovf) begin
        ovf_d = 1'b1;
      end else if (op_unf) begin
        unf_d = 1'b1;
      end else begin
        unique case (i_OP)
          OP_PUSH, OP_DUP, OP_OVER: begin
            sp_d    = sp_q + 16'd1;
            depth_d = depth_q + DepthOne;
            write_d = 1'b1;
            waddr_d = sp_q + 16'd1;
            wdata_d = (i_OP == OP_PUSH) ? i_DATA :
                      (i_OP == OP_DUP)  ? i_OP1  : i_OP2;
          end
          OP_DROP: begin
            sp_d    = sp_q - 16'd1;
            depth_d = depth_q - DepthOne;
          end
          OP_SWAP: begin
            write_d = 1'b1;
            waddr_d = sp_q - 16'd1;
            wdata_d = i_OP1;
            hold_d  = i_OP2;
          end
          OP_BINOP: begin
            sp_d    = sp_q - 16'd1;
            depth_d = depth_q - DepthOne;
            write_d = 1'b1;
            waddr_d = sp_q - 16'd1;
            wdata_d = i_DATA;
          end
          OP_CLEAR: begin
            sp_d    = SpEmpty;
            depth_d = DepthZero;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  // Datapath registers; reset overrides a pending second SWAP write.
  always_ff @(posedge c_CLOCK) begin
    if (!f_RESETN) begin
      sp_q    <= SpEmpty;
      depth_q <= DepthZero;
      write_q <= 1'b0;
      waddr_q <= 16'd0;
      wdata_q <= 16'd0;
      hold_q  <= 16'd0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      sp_q    <= sp_d;
      depth_q <= depth_d;
      write_q <= write_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

endmodule

// File: doc/dstack_ctrl.md
Name: dstack_ctrl

Overview:
- Data-stack controller that sits directly upstream of the stack memory: turns Forth stack-op requests into memory read/write addresses, write data and write strobes.
- Holds the stack pointer (SP = address of top-of-stack) and the depth count, and flags overflow/underflow.
- Receives the memory's TOS/NOS read-back (OP1 = mem[SP], OP2 = mem[SP-1]) so that DUP, SWAP and OVER need no ALU.
- Stack grows upward from BASE_ADDR.

Parameters:
- BASE_ADDR, 16'd32: address of the first stack cell; must be >= 1.
- STACK_SIZE, 32: maximum depth in cells; BASE_ADDR+STACK_SIZE-1 must be a valid memory address.
- DEPTH_W, 6: width of o_DEPTH; must hold 0..STACK_SIZE.

Ports:
- c_CLOCK  in  1  single clock, rising edge
- f_RESETN  in  1  synchronous reset, active-low
- i_VALID  in  1  op request valid
- o_READY  out  1  controller can accept an op
- i_OP  in  3  op code (see Behaviour)
- i_DATA  in  16  push value / ALU result
- i_OP1  in  16  memory read-back of mem[o_RADDR]
- i_OP2  in  16  memory read-back of mem[o_RADDR-1]
- o_RADDR  out  16  current SP, drives the memory read address
- o_WADDR  out  16  memory write address
- o_DATA  out  16  memory write data
- f_WRITE  out  1  write strobe, one cycle per write
- o_DEPTH  out  DEPTH_W  current stack depth
- f_OVF  out  1  sticky overflow flag
- f_UNF  out  1  sticky underflow flag

Behaviour:
- Clock and reset: one clock, c_CLOCK. Reset f_RESETN is synchronous and active-low.
- Reset state (f_RESETN=0 at an edge), taking priority over everything including WRITE2:
  - SP = BASE_ADDR-1, depth = 0.
  - f_WRITE = 0, o_WADDR = 0, o_DATA = 0.
  - f_OVF = f_UNF = 0, state = IDLE.
- o_RADDR = SP at all times. o_READY = 1 only in IDLE.
- Accept occurs on a rising edge with i_VALID & o_READY. i_OP1 and i_OP2 must be valid for the current SP at that edge; the SETTLE state guarantees this.
- Op codes and required depth:
  - 0 NOP: no effect, stay IDLE.
  - 1 PUSH (depth < STACK_SIZE): SP+1, write i_DATA at new SP.
  - 2 DROP (depth >= 1): SP-1, no write.
  - 3 DUP (1 <= depth < STACK_SIZE): SP+1, write i_OP1 at new SP.
  - 4 SWAP (depth >= 2): write i_OP1 at SP-1, then i_OP2 at SP; SP unchanged.
  - 5 OVER (2 <= depth < STACK_SIZE): SP+1, write i_OP2 at new SP.
  - 6 BINOP (depth >= 2): SP-1, write i_DATA at new SP. i_DATA is the ALU result of OP2 op OP1.
  - 7 CLEAR: SP = BASE_ADDR-1, depth 0, clears f_OVF and f_UNF.
- Depth violations:
  - A push-type op (PUSH, DUP, OVER) at depth == STACK_SIZE: no write, no SP change, f_OVF set, stay IDLE.
  - Insufficient depth for DROP, DUP, SWAP, OVER or BINOP: no write, no SP change, f_UNF set, stay IDLE.
  - DUP at depth 0 sets f_UNF, not f_OVF.
  - Flags are sticky until CLEAR or reset.
- Latency:
  - f_WRITE, o_WADDR and o_DATA are registered and valid the cycle after the accept edge, for exactly one cycle.
  - SP and depth update at the accept edge.
- FSM: IDLE, WRITE2, SETTLE.
  - IDLE, legal op that changes SP or writes (except SWAP) -> SETTLE.
  - IDLE, legal SWAP -> WRITE2. First write issued; i_OP2 latched into a holding register.
  - IDLE, NOP or violating op -> IDLE.
  - WRITE2 -> SETTLE. Second write (latched OP2 at SP) issued.
  - SETTLE -> IDLE. One cycle with o_READY = 0 so memory read-back tracks the new SP.
- Throughput: 2 cycles per op; SWAP takes 3. NOP and violating ops take 1.
- i_OP, i_DATA and i_VALID are ignored when o_READY = 0.
- Widths: SP arithmetic is 16-bit. SP never leaves BASE_ADDR-1 .. BASE_ADDR+STACK_SIZE-1.

Decomposition:
- Shared package dstack_pkg:
  - op-code constants OP_NOP .. OP_CLEAR
  - FSM state encodings
  - default BASE_ADDR and STACK_SIZE
- No sub-module. The FSM, SP/depth registers and write register stay in one module, since no piece is reused elsewhere.

Test Plan:
- Reset, then PUSH 16'h1111, 16'h2222 -> writes at 32 then 33; o_RADDR=33, o_DEPTH=2; o_READY low one cycle after each accept.
- From [1111,2222], SWAP with i_OP1=2222, i_OP2=1111 -> writes (32,2222) then (33,1111) on consecutive cycles; o_RADDR stays 33; o_READY low 2 cycles.
- DUP at depth 0 -> no f_WRITE, f_UNF=1, o_RADDR=31. Then CLEAR -> f_UNF=0.
- 32 PUSHes then PUSH 16'hBEEF -> 33rd push produces no write, f_OVF=1, o_DEPTH=32, o_RADDR=63.
- Depth 2, BINOP with i_DATA=16'h3333 -> write (32,3333), o_RADDR=32, o_DEPTH=1. Then OVER -> f_UNF=1, no write.
- SWAP accepted, f_RESETN=0 on the next edge -> no second write, f_WRITE=0, o_RADDR=31, o_DEPTH=0, o_READY=1.
